mem_port_arbiter: RTL

Shares the single cacheline memory port between the instruction-cache miss path, the data-cache miss/writeback path and the next-line prefetcher. It sits between the cache/prefetch blocks and the cacheline adapter. Only one transaction is outstanding at a time. Demand requests have priority over prefetch, and a starvation counter bounds how long a prefetch can wait.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/arb_priority_sel.sv | 20 ++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width defaults for the cacheline memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_I  = 2'd1,
    GNT_D  = 2'd2,
    GNT_PF = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_I    = 2'd1,
    REQ_D    = 2'd2,
    REQ_PF   = 2'd3
  } requester_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals around the arbiter.
// slave = the arbiter itself, master = caches, prefetcher and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pf_read;
  logic [ADDR_W-1:0] pf_address;
  logic [LINE_W-1:0] pf_rdata;
  logic              pf_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pf_read, pf_address, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pf_rdata, pf_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pf_read, pf_address, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pf_rdata, pf_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/arb_priority_sel.sv
// Three-way requester pick: d > i > pf, unless a starving pf is forced through.
module arb_priority_sel
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       pf_req,
  input  logic       force_pf,
  output requester_t sel
);

  always_comb begin
    sel = REQ_NONE;
    if (force_pf && pf_req) sel = REQ_PF;
    else if (d_req)         sel = REQ_D;
    else if (i_req)         sel = REQ_I;
    else if (pf_req)        sel = REQ_PF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the shared cacheline memory port.
// Demand beats prefetch; starve_cnt bounds how long a pending prefetch waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int LINE_W          = LINE_W_DEF,
  parameter int PF_STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(PF_STARVE_LIMIT + 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic              starved;
  requester_t        win;

  assign starved = (starve_cnt == CNT_W'(PF_STARVE_LIMIT));

  arb_priority_sel u_sel (
    .i_req    (bus.i_read),
    .d_req    (bus.d_read | bus.d_write),
    .pf_req   (bus.pf_read),
    .force_pf (starved),
    .sel      (win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (win)
            REQ_D: begin
              state         <= GNT_D;
              mem_address_q <= bus.d_address;
              mem_read_q    <= bus.d_read;
              mem_write_q   <= bus.d_write;
              if (bus.d_write) mem_wdata_q <= bus.d_wdata;
            end
            REQ_I: begin
              state         <= GNT_I;
              mem_address_q <= bus.i_address;
              mem_read_q    <= 1'b1;
            end
            REQ_PF: begin
              state         <= GNT_PF;
              mem_address_q <= bus.pf_address;
              mem_read_q    <= 1'b1;
            end
            default: ;
          endcase
          // Count only demand grants that jump a waiting prefetch.
          if (!bus.pf_read || win == REQ_PF)
            starve_cnt <= '0;
          else if ((win == REQ_I || win == REQ_D) && !starved)
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
        default: begin
          if (bus.mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;

  // Completion is routed combinationally so the owner sees it in the mem_resp cycle.
  assign bus.i_resp  = (state == GNT_I)  && bus.mem_resp;
  assign bus.d_resp  = (state == GNT_D)  && bus.mem_resp;
  assign bus.pf_resp = (state == GNT_PF) && bus.mem_resp;

  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;
  assign bus.pf_rdata = bus.mem_rdata;

endmodule
